// File: rtl/spi_controller_byte.sv
// spi_controller_byte: SPI mode-0 initiator byte engine.
// One byte each way per transfer, MSB first; CS held across non-last bytes.
module spi_controller_byte #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk_sys_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       spi_sclk_o,
  output logic       spi_cs_no,
  output logic       spi_tx_o,
  input  logic       spi_rx_i
);

  localparam int DW =
    (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_TOP =
    DW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    HOLD,
    DESEL
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [7:0]    tx_sh_q;
  logic [7:0]    rx_sh_q;
  logic [7:0]    rx_byte_q;
  logic          last_q;
  logic          rx_valid_q;
  logic          sclk_q;
  logic          cs_n_q;
  logic          tx_q;

  logic accept;
  logic phase_end;

  assign ready_o   = (state_q == IDLE) ||
                     (state_q == WAIT);
  assign busy_o    = (state_q != IDLE);
  assign accept    = start_i && ready_o;
  assign phase_end = (div_q == '0);

  assign rx_byte_o  = rx_byte_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_sclk_o = sclk_q;
  assign spi_cs_no  = cs_n_q;
  assign spi_tx_o   = tx_q;

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!phase_end) begin
        div_q <= div_q - DW'(1);
      end
      unique case (state_q)
        IDLE, WAIT: begin
          if (accept) begin
            tx_sh_q <= tx_byte_i;
            last_q  <= last_i;
            bit_q   <= 3'd7;
            cs_n_q  <= 1'b0;
            tx_q    <= tx_byte_i[7];
            div_q   <= DIV_TOP;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[6:0], spi_rx_i};
            div_q   <= DIV_TOP;
            state_q <= HIGH;
            // final rise completes the received byte
            if (bit_q == 3'd0) begin
              rx_byte_q  <= {rx_sh_q[6:0], spi_rx_i};
              rx_valid_q <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            div_q  <= DIV_TOP;
            if (bit_q != 3'd0) begin
              bit_q   <= bit_q - 3'd1;
              tx_sh_q <= {tx_sh_q[6:0], 1'b0};
              tx_q    <= tx_sh_q[6];
              state_q <= LOW;
            end else begin
              state_q <= last_q ? HOLD : WAIT;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            cs_n_q  <= 1'b1;
            div_q   <= DIV_TOP;
            state_q <= DESEL;
          end
        end
        DESEL: begin
          if (phase_end) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller_byte.sv
// Bench for spi_controller_byte: two instances (H=4, H=2),
// each looped to a behavioural mode-0 target.
module tb_spi_controller_byte;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       startA = 0, lastA = 0;
  logic [7:0] txA = 0;
  logic       readyA, busyA, rxvA, sclkA, csA, mosiA;
  logic [7:0] rxbA;
  logic       misoA = 0;

  logic       startB = 0, lastB = 0;
  logic [7:0] txB = 0;
  logic       readyB, busyB, rxvB, sclkB, csB, mosiB;
  logic [7:0] rxbB;
  logic       misoB = 0;

  spi_controller_byte #(.HALF_PERIOD(4)) dutA (
    .clk_sys_i(clk), .reset_i(rst), .start_i(startA),
    .tx_byte_i(txA), .last_i(lastA), .ready_o(readyA),
    .busy_o(busyA), .rx_byte_o(rxbA), .rx_valid_o(rxvA),
    .spi_sclk_o(sclkA), .spi_cs_no(csA), .spi_tx_o(mosiA),
    .spi_rx_i(misoA));

  spi_controller_byte #(.HALF_PERIOD(2)) dutB (
    .clk_sys_i(clk), .reset_i(rst), .start_i(startB),
    .tx_byte_i(txB), .last_i(lastB), .ready_o(readyB),
    .busy_o(busyB), .rx_byte_o(rxbB), .rx_valid_o(rxvB),
    .spi_sclk_o(sclkB), .spi_cs_no(csB), .spi_tx_o(mosiB),
    .spi_rx_i(misoB));

  int n_cmp = 0;
  int n_bad = 0;

  // target A
  logic [7:0] respA [4];
  logic [7:0] tgotA [16];
  int         ntgotA = 0;
  int         tbitA = 0, tbyteA = 0;
  logic [7:0] tshA = 0, trxA = 0;
  logic       tpcsA = 1, tpsA = 0;

  always @(csA, sclkA) begin
    if (tpcsA && !csA) begin
      tbitA = 0; tbyteA = 0;
      tshA = respA[0]; misoA = tshA[7];
    end else if (!csA && sclkA && !tpsA) begin
      trxA = {trxA[6:0], mosiA};
      tbitA++;
      if (tbitA == 8) begin
        tgotA[ntgotA[3:0]] = trxA; ntgotA++;
      end
    end else if (!csA && !sclkA && tpsA) begin
      if (tbitA == 8) begin
        tbitA = 0; tbyteA++;
        tshA = respA[tbyteA[1:0]];
      end else begin
        tshA = {tshA[6:0], 1'b0};
      end
      misoA = tshA[7];
    end
    tpcsA = csA; tpsA = sclkA;
  end

  // target B
  logic [7:0] respB [4];
  logic [7:0] tgotB [16];
  int         ntgotB = 0;
  int         tbitB = 0, tbyteB = 0;
  logic [7:0] tshB = 0, trxB = 0;
  logic       tpcsB = 1, tpsB = 0;

  always @(csB, sclkB) begin
    if (tpcsB && !csB) begin
      tbitB = 0; tbyteB = 0;
      tshB = respB[0]; misoB = tshB[7];
    end else if (!csB && sclkB && !tpsB) begin
      trxB = {trxB[6:0], mosiB};
      tbitB++;
      if (tbitB == 8) begin
        tgotB[ntgotB[3:0]] = trxB; ntgotB++;
      end
    end else if (!csB && !sclkB && tpsB) begin
      if (tbitB == 8) begin
        tbitB = 0; tbyteB++;
        tshB = respB[tbyteB[1:0]];
      end else begin
        tshB = {tshB[6:0], 1'b0};
      end
      misoB = tshB[7];
    end
    tpcsB = csB; tpsB = sclkB;
  end

  // cycle monitor, sampled 1 time unit after each rising edge
  int   cyc = 0;
  int   nr = 0, nv = 0, ncf = 0, ncr = 0;
  int   cf_t = 0, cr_t = 0, rdy_t = 0;
  int   rise_t [256];
  logic rise_m [256];
  int   rxv_t [32];
  logic [7:0] rxv_b [32];
  logic pcs = 1, psc = 0, prdy = 1;

  int   nrB = 0, nvB = 0, cfB_t = 0, crB_t = 0;
  int   riseB_t [64];
  logic [7:0] rxvB_b [16];
  logic pcsB = 1, pscB = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (pcs && !csA) begin cf_t = cyc; ncf++; end
    if (!pcs && csA) begin cr_t = cyc; ncr++; end
    if (!psc && sclkA) begin
      rise_t[nr[7:0]] = cyc; rise_m[nr[7:0]] = mosiA; nr++;
    end
    if (!prdy && readyA) rdy_t = cyc;
    if (rxvA) begin
      rxv_t[nv[4:0]] = cyc; rxv_b[nv[4:0]] = rxbA; nv++;
    end
    pcs = csA; psc = sclkA; prdy = readyA;
    if (pcsB && !csB) cfB_t = cyc;
    if (!pcsB && csB) crB_t = cyc;
    if (!pscB && sclkB) begin
      riseB_t[nrB[5:0]] = cyc; nrB++;
    end
    if (rxvB) begin rxvB_b[nvB[3:0]] = rxbB; nvB++; end
    pcsB = csB; pscB = sclkB;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[7-i] = rise_m[base+i];
    return m;
  endfunction

  function automatic int bad_spacing(input int base, input int n);
    int b = 0;
    for (int i = 1; i < n; i++)
      if (rise_t[base+i] - rise_t[base+i-1] != 8) b++;
    return b;
  endfunction

  task automatic sendA(input logic [7:0] b, input logic l);
    int k = 0;
    @(negedge clk);
    while (!readyA && k < 400) begin @(negedge clk); k++; end
    if (!readyA) chk("sendA_ready_timeout", 0, 1);
    startA = 1; txA = b; lastA = l;
    @(negedge clk);
    startA = 0;
  endtask

  task automatic sendB(input logic [7:0] b, input logic l);
    int k = 0;
    @(negedge clk);
    while (!readyB && k < 400) begin @(negedge clk); k++; end
    if (!readyB) chk("sendB_ready_timeout", 0, 1);
    startB = 1; txB = b; lastB = l;
    @(negedge clk);
    startB = 0;
  endtask

  task automatic idleA();
    int k = 0;
    while (busyA && k < 500) begin @(negedge clk); k++; end
    if (busyA) chk("idleA_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nr0, nv0, ncr0, ncf0, ng0, sb, k;

    vt[0] = '{8'hDA, 8'h5B, 8'hDA, 8'h5B};
    vt[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vt[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vt[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};

    // asynchronous reset between edges
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_cs_n", csA, 1);
    chk("rst_sclk", sclkA, 0);
    chk("rst_tx", mosiA, 0);
    chk("rst_rx_valid", rxvA, 0);
    chk("rst_rx_byte", rxbA, 8'h00);
    chk("rst_ready", readyA, 1);
    chk("rst_busy", busyA, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // single-byte table
    for (int t = 0; t < 4; t++) begin
      respA[0] = vt[t].resp;
      nr0 = nr; nv0 = nv; ncr0 = ncr; ng0 = ntgotA;
      sendA(vt[t].tx, 1'b1);
      idleA();
      chk($sformatf("v%0d_rises", t), nr - nr0, 8);
      chk($sformatf("v%0d_mosi", t), mosi_byte(nr0),
          vt[t].exp_mosi);
      chk($sformatf("v%0d_first_rise", t),
          rise_t[nr0] - cf_t, 4);
      chk($sformatf("v%0d_spacing", t),
          bad_spacing(nr0, 8), 0);
      chk($sformatf("v%0d_rxv_cnt", t), nv - nv0, 1);
      chk($sformatf("v%0d_rxv_time", t),
          rxv_t[nv0[4:0]] - cf_t, 60);
      chk($sformatf("v%0d_rx_byte", t),
          rxv_b[nv0[4:0]], vt[t].exp_rx);
      chk($sformatf("v%0d_cs_rise", t), cr_t - cf_t, 68);
      chk($sformatf("v%0d_cs_cnt", t), ncr - ncr0, 1);
      chk($sformatf("v%0d_ready_back", t),
          rdy_t - cf_t, 72);
      chk($sformatf("v%0d_target_rx", t),
          tgotA[ng0[3:0]], vt[t].tx);
      chk($sformatf("v%0d_rx_hold", t), rxbA, vt[t].exp_rx);
    end

    // two-byte frame, second byte accepted in first WAIT cycle
    respA[0] = 8'h5B; respA[1] = 8'hDA;
    nr0 = nr; nv0 = nv; ncr0 = ncr; ncf0 = ncf; ng0 = ntgotA;
    sendA(8'hDA, 1'b0);
    sendA(8'h5B, 1'b1);
    idleA();
    chk("two_rises", nr - nr0, 16);
    chk("two_mosi0", mosi_byte(nr0), 8'hDA);
    chk("two_mosi1", mosi_byte(nr0 + 8), 8'h5B);
    chk("two_b1_first_rise", rise_t[nr0 + 8] - cf_t, 69);
    chk("two_rxv_cnt", nv - nv0, 2);
    chk("two_rx0", rxv_b[nv0[4:0]], 8'h5B);
    chk("two_rx1", rxv_b[(nv0 + 1) % 32], 8'hDA);
    chk("two_rxv1_time", rxv_t[(nv0 + 1) % 32] - cf_t, 125);
    chk("two_cs_fall_cnt", ncf - ncf0, 1);
    chk("two_cs_rise_cnt", ncr - ncr0, 1);
    chk("two_cs_rise", cr_t - cf_t, 133);
    chk("two_tgt0", tgotA[ng0[3:0]], 8'hDA);
    chk("two_tgt1", tgotA[(ng0 + 1) % 16], 8'h5B);

    // stall in WAIT
    respA[0] = 8'h3C; respA[1] = 8'hC3;
    nr0 = nr; nv0 = nv; ncr0 = ncr; ng0 = ntgotA;
    sendA(8'hDA, 1'b0);
    k = 0;
    while (!readyA && k < 200) begin @(negedge clk); k++; end
    chk("stall_reach_wait", readyA, 1);
    sb = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (csA !== 0 || sclkA !== 0 || readyA !== 1) sb++;
    end
    chk("stall_hold", sb, 0);
    chk("stall_rises", nr - nr0, 8);
    sendA(8'h5B, 1'b1);
    idleA();
    chk("stall_total_rises", nr - nr0, 16);
    chk("stall_mosi1", mosi_byte(nr0 + 8), 8'h5B);
    chk("stall_rx0", rxv_b[nv0[4:0]], 8'h3C);
    chk("stall_rx1", rxv_b[(nv0 + 1) % 32], 8'hC3);
    chk("stall_cs_cnt", ncr - ncr0, 1);
    chk("stall_tgt1", tgotA[(ng0 + 1) % 16], 8'h5B);

    // start pulsed during HIGH is ignored
    respA[0] = 8'h5B;
    nr0 = nr; nv0 = nv;
    sendA(8'hDA, 1'b1);
    k = 0;
    while (!sclkA && k < 50) begin @(negedge clk); k++; end
    chk("ign_in_high", sclkA, 1);
    startA = 1; txA = 8'hFF; lastA = 0;
    @(negedge clk);
    startA = 0;
    idleA();
    chk("ign_rises", nr - nr0, 8);
    chk("ign_mosi", mosi_byte(nr0), 8'hDA);
    chk("ign_rxv_cnt", nv - nv0, 1);
    chk("ign_cs_rise", cr_t - cf_t, 68);

    // reset mid-byte after 3 rises
    respA[0] = 8'hA5;
    nr0 = nr;
    sendA(8'hE7, 1'b1);
    k = 0;
    while (nr - nr0 < 3 && k < 100) begin @(negedge clk); k++; end
    chk("abort_3rises", nr - nr0, 3);
    #2 rst = 1;
    #1;
    chk("abort_cs_n", csA, 1);
    chk("abort_sclk", sclkA, 0);
    chk("abort_tx", mosiA, 0);
    chk("abort_rx_byte", rxbA, 8'h00);
    chk("abort_ready", readyA, 1);
    @(negedge clk);
    rst = 0;
    respA[0] = 8'h5B;
    nr0 = nr; nv0 = nv; ng0 = ntgotA;
    sendA(8'hDA, 1'b1);
    idleA();
    chk("post_mosi", mosi_byte(nr0), 8'hDA);
    chk("post_rx", rxv_b[nv0[4:0]], 8'h5B);
    chk("post_rxv_time", rxv_t[nv0[4:0]] - cf_t, 60);
    chk("post_tgt", tgotA[ng0[3:0]], 8'hDA);

    // HALF_PERIOD = 2, two-byte frame
    respB[0] = 8'h3C; respB[1] = 8'hA5;
    sendB(8'hA5, 1'b0);
    sendB(8'h3C, 1'b1);
    k = 0;
    while (busyB && k < 300) begin @(negedge clk); k++; end
    chk("hp2_idle", busyB, 0);
    chk("hp2_rises", nrB, 16);
    chk("hp2_first_rise", riseB_t[0] - cfB_t, 2);
    sb = 0;
    for (int i = 1; i < 16; i++)
      if (i != 8 && riseB_t[i] - riseB_t[i-1] != 4) sb++;
    chk("hp2_spacing", sb, 0);
    chk("hp2_rxv_cnt", nvB, 2);
    chk("hp2_rx0", rxvB_b[0], 8'h3C);
    chk("hp2_rx1", rxvB_b[1], 8'hA5);
    chk("hp2_tgt0", tgotB[0], 8'hA5);
    chk("hp2_tgt1", tgotB[1], 8'h3C);
    chk("hp2_cs_rise", crB_t - cfB_t, 67);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_controller_byte.md
Name: spi_controller_byte

Overview:
- SPI mode 0 (CPOL=0, CPHA=0) controller byte engine, clocked by clk_sys. It is the initiator end of the link served by the spi_byte target.
- Generates spi_sclk, spi_cs_n and MOSI from clk_sys, and shifts one byte out and one byte in per transfer, MSB first.
- Host logic feeds bytes through a ready/start handshake. A per-byte "last" flag chooses between keeping CS asserted for a multi-byte frame and ending the frame.
- Used by the verification model and by bridge logic that drives spi_byte-style targets.

Parameters:
- HALF_PERIOD, 4: clk_sys cycles per SCLK phase (low or high). Minimum is 2. The target double-syncs SCLK/CS_N, so 4 is recommended.

Ports:
- clk_sys_i  in  1  system clock; all logic is on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request to send tx_byte_i; accepted only when start_i and ready_o are both high
- tx_byte_i  in  8  byte to send; sampled on accept
- last_i  in  1  sampled on accept; 1 deasserts CS after this byte
- ready_o  out  1  engine can accept a byte this cycle
- busy_o  out  1  frame in progress (spi_cs_no low, or in the CS hold/deassert phases)
- rx_byte_o  out  8  last received byte
- rx_valid_o  out  1  one-cycle pulse; rx_byte_o is new
- spi_sclk_o  out  1  SPI clock, registered
- spi_cs_no  out  1  chip select, active low, registered
- spi_tx_o  out  1  MOSI, registered
- spi_rx_i  in  1  MISO

Behaviour:
- Reset (asynchronous, takes effect at once including mid-byte):
  - State IDLE, spi_cs_no=1, spi_sclk_o=0, spi_tx_o=0.
  - rx_byte_o=0, rx_valid_o=0, busy_o=0, ready_o=1.
  - Divider, bit counter and shift registers cleared.
- States: IDLE, LOW, HIGH, WAIT, HOLD, DESEL.
- Divider: counts HALF_PERIOD-1 down to 0. Every phase (LOW, HIGH, HOLD, DESEL) lasts exactly HALF_PERIOD cycles.
- IDLE:
  - ready_o=1, spi_cs_no=1, spi_sclk_o=0.
  - On accept, the next edge loads the tx shift register, stores last_i, and sets bit count to 7.
  - The same edge drives spi_cs_no=0 and spi_tx_o=tx_byte_i[7], then goes to LOW.
- LOW:
  - spi_sclk_o=0, MOSI stable.
  - At phase end, the edge sets spi_sclk_o=1, samples spi_rx_i into rx shift bit 0 (shift left), and goes to HIGH.
- HIGH, phase end:
  - If bits remain: set spi_sclk_o=0, drive the next MOSI bit on the same edge, decrement the count, go to LOW.
  - After bit 0: set spi_sclk_o=0, then go to HOLD if last=1, else WAIT.
- Receive timing:
  - On the edge that raises SCLK for bit 0, rx_byte_o <= {rx_shift[6:0], spi_rx_i}.
  - rx_valid_o=1 for that single cycle.
  - rx_valid_o is therefore first visible together with the 8th SCLK high.
- WAIT (multi-byte frame continuing):
  - spi_cs_no=0, spi_sclk_o=0, ready_o=1.
  - Waits indefinitely.
  - On accept, loads the byte and drives MOSI=MSB, then goes to LOW (a full HALF_PERIOD low before the first rise).
- HOLD:
  - spi_cs_no=0, spi_sclk_o=0 for HALF_PERIOD cycles.
  - Then spi_cs_no=1 and go to DESEL.
- DESEL:
  - spi_cs_no=1 for HALF_PERIOD cycles (guarantees the target sees CS_N high), then IDLE.
  - ready_o=0 throughout HOLD and DESEL.
- ready_o is 1 only in IDLE and WAIT. start_i while ready_o=0 is ignored, not queued.
- Timing with cs_n falling at cycle T and H=HALF_PERIOD:
  - Bit k (k=0 for the MSB) rises at T+H+2kH.
  - rx_valid_o is high at T+15H.
  - For a last byte, spi_cs_no rises at T+17H and ready_o returns at T+18H.
- spi_tx_o keeps its last driven value after a frame.
- busy_o = (state != IDLE).

Test Plan:
- Reset: assert reset_i asynchronously between clk edges -> outputs immediately cs_n=1, sclk=0, tx=0, rx_valid=0, rx_byte=$00, ready=1.
- Single byte, H=4: bench target model returns $5B; start with tx=$DA, last=1 -> MOSI=1,1,0,1,1,0,1,0 sampled at 8 SCLK rises spaced 8 cycles apart, first rise 4 cycles after cs_n falls. rx_valid is one pulse 60 cycles after cs_n falls with rx_byte=$5B. cs_n rises 68 cycles after falling.
- Two-byte frame: $DA (last=0) then $5B (last=1) accepted the first WAIT cycle -> cs_n low continuously, 16 rises, two rx_valid pulses with rx_byte equal to the target's $5B then $DA, single cs_n deassert at the end.
- Stall: $DA with last=0, start_i held low for 30 cycles -> cs_n stays 0, sclk stays 0, ready=1, no extra edges. A later $5B (last=1) completes the frame normally.
- Abort/ignore: start_i pulsed during HIGH with $FF -> ignored, MOSI unchanged. Reset after 3 rises -> cs_n=1 immediately; a following $DA transfer is bit-exact.
- HALF_PERIOD=2: looped to spi_byte with $A5/$3C -> correct bytes both directions, rises every 4 cycles.
